// File: rtl/serializer_if.sv
// rtl/serializer_if.sv - payload word valid/ready handshake into the serializer
interface serializer_if;
    logic [27:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serializer.sv
// rtl/serializer.sv - 28-bit word to MSB-first serial frame with 1010 header and idle gap
module serializer #(
    parameter int GAP_BITS = 4
) (
    input  logic         t_clk,
    input  logic         rst_n,
    serializer_if.slave  tx,
    output logic         ser_out,
    output logic         busy,
    output logic         frame_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD, ST_GAP} state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [27:0] shift_q, shift_d;
    logic [27:0] buf_q, buf_d;
    logic        full_q, full_d;
    logic        ser_out_q, ser_out_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        accept;
    logic        load;

    // Ready comes straight from the full flag so it never depends on tx_valid.
    assign tx.tx_ready = ~full_q;
    assign accept      = tx.tx_valid & ~full_q;
    assign ser_out     = ser_out_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

    // State and datapath registers; the serial line idles high out of reset.
    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 5'd0;
            gap_cnt_q    <= 4'd0;
            shift_q      <= 28'd0;
            buf_q        <= 28'd0;
            full_q       <= 1'b0;
            ser_out_q    <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            shift_q      <= shift_d;
            buf_q        <= buf_d;
            full_q       <= full_d;
            ser_out_q    <= ser_out_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next engine state; a full buffer at the end of the gap chains straight into a header.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q) begin
                    state_d = ST_HEADER;
                    load    = 1'b1;
                end
            end
            ST_HEADER: begin
                if (bit_cnt_q == 5'd3) state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (bit_cnt_q == 5'd27) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (full_q) begin
                        state_d = ST_HEADER;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Buffer, counters and the registered line value for the state being entered.
    always_comb begin
        full_d = full_q;
        buf_d  = buf_q;
        if (accept) begin
            full_d = 1'b1;
            buf_d  = tx.tx_data;
        end else if (load) begin
            full_d = 1'b0;
        end

        shift_d = shift_q;
        if (load) begin
            shift_d = buf_q;
        end else if (state_q == ST_PAYLOAD && state_d == ST_PAYLOAD) begin
            shift_d = {shift_q[26:0], 1'b0};
        end

        bit_cnt_d = 5'd0;
        gap_cnt_d = 4'd0;
        if (state_d == state_q) begin
            if (state_q == ST_HEADER || state_q == ST_PAYLOAD) bit_cnt_d = bit_cnt_q + 5'd1;
            if (state_q == ST_GAP) gap_cnt_d = gap_cnt_q + 4'd1;
        end

        case (state_d)
            ST_HEADER:  ser_out_d = ~bit_cnt_d[0];
            ST_PAYLOAD: ser_out_d = shift_d[27];
            default:    ser_out_d = 1'b1;
        endcase

        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);
    end

endmodule

// File: doc/serializer.md
# serializer

Transmit-side counterpart of the self-test deserializer. Accepts a 28-bit payload word over a valid/ready handshake and shifts it out MSB-first on a single serial line as a 32-bit frame: the 4-bit header 1010 followed by 28 payload bits. Each frame is followed by an idle gap of logic-1 bits. A one-entry holding buffer allows back-to-back frames with no gap beyond GAP_BITS. The block drives the same serial line that the deserializer samples on the same clock, and produces the 4-byte sequence that the deserializer presents.

## Interface
- GAP_BITS, 4: number of idle 1 bits driven after every frame; legal range 1..15.
- t_clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  28  payload word; bit 27 is transmitted first.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  the block can accept a word; a transfer occurs on any edge with tx_valid & tx_ready.
- ser_out  output  1  serial line, registered; idles at 1.
- busy  output  1  the shift engine is in HEADER, PAYLOAD or GAP.
- frame_done  output  1  one-cycle pulse when the last gap bit of a frame ends.

## Operation
- Holding buffer: 28-bit register plus a full flag.
  - tx_ready is the inverse of the full flag, decoded from a register and not from tx_valid.
  - A transfer sets full and captures tx_data.
  - When the engine loads the buffer, full clears.
  - No accept and load can occur on the same edge, because tx_ready is low while the buffer is full.
- Engine states:
  - IDLE: ser_out = 1. If the buffer is full, load it into the 28-bit shift register, go to HEADER, and clear full.
  - HEADER: drive 1, 0, 1, 0 on successive cycles (4 cycles), then go to PAYLOAD.
  - PAYLOAD: drive shift[27] and shift left by one each cycle, for 28 cycles; then go to GAP.
  - GAP: drive 1 for GAP_BITS cycles. On the final gap cycle:
    - frame_done pulses on the following cycle.
    - If the buffer is full, load it and go to HEADER with no extra idle cycle; otherwise go to IDLE.
- Counters:
  - 5-bit bit counter for HEADER/PAYLOAD, counting 0..3 and then 0..27.
  - 4-bit gap counter.
  - Both counters clear on every state change.
- Frame contents as seen by the deserializer: byte0 = {1010, tx_data[27:24]}, byte1 = tx_data[23:16], byte2 = tx_data[15:8], byte3 = tx_data[7:0].
- The idle level is 1 and the gap is at least 1 bit. Together these guarantee that the receiver's 4-bit window never matches 1010 outside a header.
- busy is high in HEADER, PAYLOAD and GAP; it is low only in IDLE.

## Timing
- Reset values: ser_out = 1, tx_ready = 1, busy = 0, frame_done = 0, engine in IDLE, buffer empty.
- Reset asserted mid-frame:
  - ser_out returns to 1 immediately (asynchronous reset).
  - The frame in progress and any buffered word are discarded.
  - No frame_done pulse is generated.
- Latency, with the word accepted on edge E while the engine is IDLE:
  - Buffer loads on E; the engine loads on E+1; busy = 1 and ser_out = header bit 1 after E+1.
  - Header occupies the cycles after edges E+1..E+4.
  - Payload bit 27-k is on ser_out after edge E+5+k, for k = 0..27.
  - Gap occupies the cycles after edges E+33..E+32+GAP_BITS.
  - frame_done = 1 for the single cycle after edge E+33+GAP_BITS.
  - busy falls after edge E+33+GAP_BITS unless another frame starts on that edge.
- tx_ready falls after edge E and rises after edge E+1.
- Back-to-back: when the buffer is full at the end of the gap, the next header bit 1 appears after the same edge that ends the gap. Frame period is 32+GAP_BITS cycles.
- A word offered while the engine is busy is accepted immediately if the buffer is empty. tx_ready then stays low until the engine loads that word.
- tx_data is ignored on any edge where tx_valid & tx_ready is not true.

## Test plan
- Single frame: apply reset, then send tx_data = 28'hABCDEF1 with GAP_BITS = 4.
  - ser_out must read 1010 1010 1011 1100 1101 1110 1111 0001 then 1111.
  - A looped-back deserializer must output 0xAA, 0xBC, 0xDE, 0xF1.
  - frame_done must pulse exactly once, 37 cycles after acceptance.
- Back-to-back: hold tx_valid high with 28'h0000001 then 28'hFFFFFFF.
  - The second header must start immediately after the 4th gap bit of the first frame.
  - tx_ready must be low from the second accept until the second load.
  - Two frame_done pulses, 36 cycles apart.
- False-header guard: send payload 28'h000000A (ends in 1010) with GAP_BITS = 1, followed by an idle period.
  - The deserializer must not detect a second header; ser_out stays 1 after the gap.
- Handshake hold: raise tx_valid while the buffer is full and change tx_data each cycle.
  - No transfer may occur until tx_ready rises.
  - The word transmitted must be the value present on the accepting edge.
- Reset mid-payload: pull rst_n low during payload bit 10, with a word held in the buffer.
  - ser_out, tx_ready, busy and frame_done must go to 1, 1, 0, 0 asynchronously.
  - After release, the line must stay idle with no frame sent.
- GAP_BITS = 15: a single frame must show exactly 15 idle 1 bits before frame_done pulses; busy must be high for 47 cycles.
